// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared field selects, field limits and field type for the time-of-day bank
package time_pkg;

    typedef logic [6:0] field_t;

    localparam logic [1:0] SEL_SEC   = 2'b00;
    localparam logic [1:0] SEL_MIN   = 2'b01;
    localparam logic [1:0] SEL_HOUR  = 2'b10;
    localparam logic [1:0] SEL_ALARM = 2'b11;

    localparam int SEC_MAX_DEF  = 59;
    localparam int MIN_MAX_DEF  = 59;
    localparam int HOUR_MAX_DEF = 23;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - loadable modulo-(MAX+1) counter with increment enable and carry-out
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   inc         advance by one this cycle
//   load        overwrite with load_value (wins over inc)
//   load_value  value to load, assumed already range-checked
//   count       current value
//   carry       inc while count == MAX (count wraps to 0 this edge)
import time_pkg::*;

module mod_counter #(
    parameter int MAX = 59
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   inc,
    input  logic   load,
    input  field_t load_value,
    output field_t count,
    output logic   carry
);

    assign carry = inc && (count == 7'(MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= carry ? '0 : count + 7'd1;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - time-of-day register bank advancing sec/min/hour on a 1 Hz tick
//
// Optional feature macro: TIME_KEEPER_ALARM_EN (alarm registers and alarm pulse).
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   tick         one-cycle 1 Hz enable
//   run          counting enable; 0 ignores ticks and drops any pending tick
//   load_valid   one-cycle strobe qualifying load_sel/load_data
//   load_sel     00 sec, 01 min, 10 hour, 11 alarm
//   load_data    binary value for the selected field
//   sec/min/hour current time
//   day_wrap     one-cycle pulse on 23:59:59 -> 00:00:00
//   load_err     one-cycle pulse when a load is rejected
//   alarm        one-cycle pulse when a tick lands on the alarm time (0 without the macro)
import time_pkg::*;

module time_keeper #(
    parameter int SEC_MAX  = SEC_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int HOUR_MAX = HOUR_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       run,
    input  logic       load_valid,
    input  logic [1:0] load_sel,
    input  logic [6:0] load_data,
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [6:0] hour,
    output logic       day_wrap,
    output logic       load_err,
    output logic       alarm
);

    logic tick_pend;
    logic advance;
    logic load_ok;
    logic sec_ld, min_ld, hour_ld;
    logic sec_carry, min_carry, hour_carry;
`ifdef TIME_KEEPER_ALARM_EN
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       alarm_min_ld, alarm_hour_ld;
    logic       alarm_hit;
    field_t     min_after, hour_after;
`endif

    // Any load this cycle blocks the advance; the tick is parked in tick_pend instead.
    assign advance = run && (tick || tick_pend) && !load_valid;

    always_comb begin
        load_ok = 1'b0;
        sec_ld  = 1'b0;
        min_ld  = 1'b0;
        hour_ld = 1'b0;
`ifdef TIME_KEEPER_ALARM_EN
        alarm_min_ld  = 1'b0;
        alarm_hour_ld = 1'b0;
`endif
        if (load_valid) begin
            case (load_sel)
                SEL_SEC: begin
                    load_ok = (load_data <= 7'(SEC_MAX));
                    sec_ld  = load_ok;
                end
                SEL_MIN: begin
                    load_ok = (load_data <= 7'(MIN_MAX));
                    min_ld  = load_ok;
                end
                SEL_HOUR: begin
                    load_ok = (load_data <= 7'(HOUR_MAX));
                    hour_ld = load_ok;
                end
                default: begin
`ifdef TIME_KEEPER_ALARM_EN
                    // bit 6 picks hour vs minute; an hour load also requires bit 5 clear
                    if (!load_data[6]) begin
                        load_ok      = (load_data[5:0] <= 6'(MIN_MAX));
                        alarm_min_ld = load_ok;
                    end else begin
                        load_ok       = !load_data[5] && (load_data[4:0] <= 5'(HOUR_MAX));
                        alarm_hour_ld = load_ok;
                    end
`else
                    load_ok = 1'b0;
`endif
                end
            endcase
        end
    end

    mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .inc(advance), .load(sec_ld),
        .load_value(load_data), .count(sec), .carry(sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .inc(sec_carry), .load(min_ld),
        .load_value(load_data), .count(min), .carry(min_carry)
    );

    mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .inc(min_carry), .load(hour_ld),
        .load_value(load_data), .count(hour), .carry(hour_carry)
    );

    // tick_pend owes at most one tick. When a new tick meets a pending one without a load,
    // one is applied and the other stays owed; with a load both collapse to one.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_pend <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            if (!run) begin
                tick_pend <= 1'b0;
            end else if (load_valid) begin
                tick_pend <= tick_pend || tick;
            end else if (advance) begin
                tick_pend <= tick_pend && tick;
            end
            day_wrap <= hour_carry;
            load_err <= load_valid && !load_ok;
        end
    end

`ifdef TIME_KEEPER_ALARM_EN
    // Time reached by this cycle's advance; only relevant when seconds wrap to 0.
    always_comb begin
        min_after  = min_carry ? '0 : min + 7'd1;
        hour_after = hour_carry ? '0 : (min_carry ? hour + 7'd1 : hour);
        alarm_hit  = advance && sec_carry &&
                     (min_after == {1'b0, alarm_min}) && (hour_after == {2'b00, alarm_hour});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_min  <= '0;
            alarm_hour <= '0;
            alarm      <= 1'b0;
        end else begin
            if (alarm_min_ld)  alarm_min  <= load_data[5:0];
            if (alarm_hour_ld) alarm_hour <= load_data[4:0];
            alarm <= alarm_hit;
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed and randomized bench for time_keeper against a seconds-of-day model
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       run = 1'b1;
    logic       load_valid = 1'b0;
    logic [1:0] load_sel = 2'b00;
    logic [6:0] load_data = 7'd0;
    logic [6:0] sec, min, hour;
    logic       day_wrap, load_err, alarm;

    int vectors = 0;
    int miscompares = 0;

    // reference state: time as seconds since midnight, owed ticks, alarm as minute-of-day
    int t_day = 0;
    int owed = 0;
    int al_h = 0;
    int al_m = 0;
    logic e_wrap = 1'b0;
    logic e_err = 1'b0;
    logic e_alarm = 1'b0;

    time_keeper dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run),
        .load_valid(load_valid), .load_sel(load_sel), .load_data(load_data),
        .sec(sec), .min(min), .hour(hour),
        .day_wrap(day_wrap), .load_err(load_err), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model(input logic r, input logic tk, input logic rn, input logic lv,
                         input logic [1:0] sl, input logic [6:0] d);
        int s, m, h, v;
        s = t_day % 60;
        m = (t_day / 60) % 60;
        h = t_day / 3600;
        v = int'(d);
        e_wrap = 1'b0;
        e_err = 1'b0;
        e_alarm = 1'b0;
        if (r) begin
            t_day = 0; owed = 0; al_h = 0; al_m = 0;
            return;
        end
        if (lv) begin
            case (sl)
                2'd0: if (v <= 59) t_day = h * 3600 + m * 60 + v; else e_err = 1'b1;
                2'd1: if (v <= 59) t_day = h * 3600 + v * 60 + s; else e_err = 1'b1;
                2'd2: if (v <= 23) t_day = v * 3600 + m * 60 + s; else e_err = 1'b1;
                default: begin
`ifdef TIME_KEEPER_ALARM_EN
                    if (v < 64) begin
                        if (v <= 59) al_m = v; else e_err = 1'b1;
                    end else begin
                        if (v - 64 <= 23) al_h = v - 64; else e_err = 1'b1;
                    end
`else
                    e_err = 1'b1;
`endif
                end
            endcase
        end
        if (!rn) begin
            owed = 0;
        end else if (lv) begin
            owed = (owed + int'(tk) > 0) ? 1 : 0;
        end else if (owed + int'(tk) > 0) begin
            owed = owed + int'(tk) - 1;
            t_day = (t_day + 1) % 86400;
            e_wrap = (t_day == 0);
`ifdef TIME_KEEPER_ALARM_EN
            e_alarm = (t_day % 60 == 0) && (t_day / 60 == al_h * 60 + al_m);
`endif
        end
    endtask

    task automatic step(input logic r, input logic tk, input logic rn, input logic lv,
                        input logic [1:0] sl, input logic [6:0] d);
        @(negedge clk);
        rst = r; tick = tk; run = rn; load_valid = lv; load_sel = sl; load_data = d;
        @(posedge clk);
        model(r, tk, rn, lv, sl, d);
        #1;
        check("sec", int'(sec), t_day % 60);
        check("min", int'(min), (t_day / 60) % 60);
        check("hour", int'(hour), t_day / 3600);
        check("day_wrap", int'(day_wrap), int'(e_wrap));
        check("load_err", int'(load_err), int'(e_err));
        check("alarm", int'(alarm), int'(e_alarm));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 7'd0);
    endtask

    task automatic load(input logic [1:0] sl, input logic [6:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b1, sl, d);
    endtask

    initial begin
        logic r, tk, rn, lv;
        logic [1:0] sl;
        logic [6:0] d;

        // reset
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'd0);
        check("reset_sec", int'(sec), 0);
        check("reset_hour", int'(hour), 0);

        // 61 ticks -> 00:01:01
        for (int i = 0; i < 61; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0);
        check("t61_sec", int'(sec), 1);
        check("t61_min", int'(min), 1);

        // 23:59:59 + tick -> midnight with one-cycle day_wrap
        load(2'd2, 7'd23);
        load(2'd1, 7'd59);
        load(2'd0, 7'd59);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0);
        check("wrap_pulse", int'(day_wrap), 1);
        check("wrap_hour", int'(hour), 0);
        idle();
        check("wrap_drop", int'(day_wrap), 0);

        // out-of-range minute rejected
        load(2'd1, 7'd60);
        check("min60_err", int'(load_err), 1);
        idle();

        // load with coincident tick: tick lands one cycle later
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 7'd10);
        check("ld_tick_sec0", int'(sec), 10);
        idle();
        check("ld_tick_sec1", int'(sec), 11);

        // run=0 ignores ticks
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0);
        check("run0_sec", int'(sec), 11);

        // reset mid-count
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0);
        check("midrst_sec", int'(sec), 0);

`ifdef TIME_KEEPER_ALARM_EN
        load(2'd3, 7'b1000111);
        load(2'd3, 7'b0011110);
        load(2'd2, 7'd7);
        load(2'd1, 7'd29);
        load(2'd0, 7'd59);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0);
        check("alarm_hit", int'(alarm), 1);
        idle();
        check("alarm_drop", int'(alarm), 0);
`else
        load(2'd3, 7'b0011110);
        check("sel11_err", int'(load_err), 1);
        idle();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            tk = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 15) != 0);
            lv = ($urandom_range(0, 7) == 0);
            sl = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 59));
            step(r, tk, rn, lv, sl, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day register bank for the digital clock: holds seconds, minutes and hours in binary and advances them on a 1 Hz tick. It sits directly downstream of the time-setting stage, consuming its field-select and 7-bit data strobe to overwrite one field. Outputs feed the display/decoder stage.

## Interface
Parameters:
- SEC_MAX, 59, last valid seconds value
- MIN_MAX, 59, last valid minutes value
- HOUR_MAX, 23, last valid hours value

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 1 Hz enable pulse
- run  in  1  1 = counting enabled; 0 = tick ignored, no pending tick recorded
- load_valid  in  1  one-cycle strobe: load_sel/load_data valid
- load_sel  in  2  00 seconds, 01 minutes, 10 hours, 11 alarm (see Configuration)
- load_data  in  7  binary value for selected field
- sec  out  7  current seconds
- min  out  7  current minutes
- hour  out  7  current hours
- day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
- load_err  out  1  one-cycle pulse when a load is rejected
- alarm  out  1  one-cycle alarm pulse (TIME_KEEPER_ALARM_EN only; else tied 0)

## Operation
- Reset: sec=min=hour=0, day_wrap=0, load_err=0, alarm=0, tick_pend=0, alarm registers=0. Reset overrides every other input in the same cycle.
- Advance (tick or tick_pend, run=1, no load this cycle): sec+1; at SEC_MAX sec->0 and min+1; at MIN_MAX min->0 and hour+1; at HOUR_MAX hour->0 and day_wrap=1 next cycle.
- Load (load_valid=1): value checked against field max; in range -> field written; out of range -> no change, load_err=1. sel=11 without macro -> load_err=1.
- Load + tick same cycle: load applied, tick deferred via tick_pend; applied next cycle (carries evaluated on loaded value). tick_pend holds at most one tick; a tick arriving while tick_pend=1 and another load occurs is dropped.
- run=0 clears tick_pend.
- Arithmetic: unsigned 7-bit; values never exceed field max; bit 6 of min/sec only used transiently for validation.

## Timing
- Outputs registered; update one cycle after tick/load edge.
- Latency tick -> sec change: 1 cycle; deferred tick: 2 cycles.
- day_wrap, load_err, alarm: exactly one cycle high, registered.
- load_valid must be a single-cycle strobe; consecutive strobes on successive cycles each processed in order.

## Configuration
- TIME_KEEPER_ALARM_EN defined: sel=11 loads alarm: load_data[6]=0 -> alarm minute=load_data[5:0] (reject >59); load_data[6]=1 -> alarm hour=load_data[4:0] (reject >23; load_data[5] must be 0). alarm pulses one cycle when a tick-driven advance lands on hour:min = alarm and sec=0. Loads never trigger alarm.
- Undefined: no alarm registers, alarm tied 0, sel=11 rejected with load_err.

## Structure
- Package time_pkg: SEL_SEC/SEL_MIN/SEL_HOUR/SEL_ALARM constants, field max constants, 7-bit field typedef.
- Sub-module mod_counter: load-able modulo-N counter with increment-enable and carry-out; instantiated for sec, min, hour.

## Test plan
- Reset then 61 ticks -> sec=1, min=1, hour=0; no day_wrap.
- Load hour=23, min=59, sec=59, one tick -> all 0, day_wrap high exactly one cycle.
- load_sel=01, load_data=60 -> min unchanged, load_err one cycle.
- load sec=10 and tick same cycle -> sec=10 next cycle, 11 the cycle after.
- run=0 with 5 ticks -> no change; rst asserted mid-count -> all outputs 0 next cycle.
- ALARM_EN: alarm 07:30 (data 7'b1000111, 7'b0011110), start 07:29:59, tick -> alarm one cycle; macro off -> sel=11 gives load_err.
